// File: rtl/uart_rx_engine.sv
// uart_rx_engine: oversampled UART receiver with majority voting, break
// detection and a show-ahead receive FIFO carrying per-character error flags.
module uart_rx_engine #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          pclk,
    input  logic          utrrst,
    input  logic          sample_edge,
    input  logic          uart_rxd,
    input  logic          loop_txd,
    input  logic          loop,
    input  logic [1:0]    wls,
    input  logic          pen,
    input  logic          eps,
    input  logic          sp,
    input  logic          rx_rd,
    input  logic          ovr_clr,
    output logic [7:0]    rx_data,
    output logic          rx_pe,
    output logic          rx_fe,
    output logic          rx_bi,
    output logic          rx_empty,
    output logic          rx_full,
    output logic [CW-1:0] rx_count,
    output logic          overrun,
    output logic          fifo_error,
    output logic          rx_busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned M  = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRKWAIT
    } state_t;

    state_t state, state_next;

    logic          sync1, sync2;
    logic          line_c;
    logic [TW-1:0] tk;
    logic          smp0, smp1;
    logic [2:0]    bit_cnt;
    logic [7:0]    data_r;
    logic          par_r;

    logic          tick_dec_c, tick_wrap_c, maj_c;
    logic [2:0]    last_bit_c;
    logic          exp_par_c, brk_c;

    logic          push_c;
    logic [7:0]    push_data_c;
    logic          push_pe_c, push_fe_c, push_bi_c;

    logic [7:0]            mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_pe, mem_fe, mem_bi, valid;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  pop_c, wr_en_c, ovf_c;
    logic [CW-1:0]         count_next_c;

    // Two-flop synchroniser for the pin; idles high out of reset
    always_ff @(posedge pclk) begin
        if (utrrst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
        end
    end

    assign line_c      = loop ? loop_txd : sync2;
    assign tick_dec_c  = sample_edge && (tk == TW'(M + 1));
    assign tick_wrap_c = sample_edge && (tk == TW'(OVERSAMPLE - 1));
    assign maj_c       = (smp0 & smp1) | (smp0 & line_c) | (smp1 & line_c);
    assign last_bit_c  = 3'(wls) + 3'd4;
    assign exp_par_c   = sp ? ~eps : (eps ? (^data_r) : ~(^data_r));
    assign brk_c       = (data_r == 8'h00) && (!pen || !par_r) && !maj_c;

    // State register; busy mirrors the next state so it is registered
    always_ff @(posedge pclk) begin
        if (utrrst) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
        end else begin
            state   <= state_next;
            rx_busy <= (state_next != S_IDLE);
        end
    end

    // Next-state decode and character push request
    always_comb begin
        state_next  = state;
        push_c      = 1'b0;
        push_data_c = data_r;
        push_pe_c   = 1'b0;
        push_fe_c   = 1'b0;
        push_bi_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (sample_edge && !line_c) state_next = S_START;
            end
            S_START: begin
                if (tick_dec_c && maj_c)  state_next = S_IDLE;
                else if (tick_wrap_c)     state_next = S_DATA;
            end
            S_DATA: begin
                if (tick_wrap_c && (bit_cnt == last_bit_c))
                    state_next = pen ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (tick_wrap_c) state_next = S_STOP;
            end
            S_STOP: begin
                if (tick_dec_c) begin
                    push_c = 1'b1;
                    if (brk_c) begin
                        push_data_c = 8'h00;
                        push_fe_c   = 1'b1;
                        push_bi_c   = 1'b1;
                        state_next  = S_BRKWAIT;
                    end else begin
                        push_pe_c  = pen && (par_r != exp_par_c);
                        push_fe_c  = !maj_c;
                        state_next = S_IDLE;
                    end
                end
            end
            S_BRKWAIT: begin
                if (sample_edge && line_c) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Tick counter, vote samples and character assembly
    always_ff @(posedge pclk) begin
        if (utrrst) begin
            tk      <= '0;
            smp0    <= 1'b1;
            smp1    <= 1'b1;
            bit_cnt <= '0;
            data_r  <= '0;
            par_r   <= 1'b0;
        end else if (state == S_IDLE) begin
            tk      <= '0;
            bit_cnt <= '0;
            data_r  <= '0;
            par_r   <= 1'b0;
        end else if (sample_edge) begin
            tk <= (tk == TW'(OVERSAMPLE - 1)) ? '0 : tk + TW'(1);
            if (tk == TW'(M - 1)) smp0 <= line_c;
            if (tk == TW'(M))     smp1 <= line_c;
            if (tk == TW'(M + 1)) begin
                if (state == S_DATA)   data_r[bit_cnt] <= maj_c;
                if (state == S_PARITY) par_r           <= maj_c;
            end
            if ((tk == TW'(OVERSAMPLE - 1)) && (state == S_DATA))
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign pop_c   = rx_rd && !rx_empty;
    assign wr_en_c = push_c && (!rx_full || pop_c);
    assign ovf_c   = push_c && rx_full && !pop_c;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next_c = rx_count;
        case ({wr_en_c, pop_c})
            2'b10:   count_next_c = rx_count + CW'(1);
            2'b01:   count_next_c = rx_count - CW'(1);
            default: count_next_c = rx_count;
        endcase
    end

    // FIFO pointers, occupancy, status flags and sticky overrun
    always_ff @(posedge pclk) begin
        if (utrrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
            rx_empty <= 1'b1;
            rx_full  <= 1'b0;
            overrun  <= 1'b0;
            valid    <= '0;
        end else begin
            if (pop_c) begin
                rd_ptr        <= rd_ptr + AW'(1);
                valid[rd_ptr] <= 1'b0;
            end
            if (wr_en_c) begin
                wr_ptr        <= wr_ptr + AW'(1);
                valid[wr_ptr] <= 1'b1;
            end
            rx_count <= count_next_c;
            rx_empty <= (count_next_c == '0);
            rx_full  <= (count_next_c == CW'(FIFO_DEPTH));
            if (ovf_c)        overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

    // FIFO storage
    always_ff @(posedge pclk) begin
        if (!utrrst && wr_en_c) begin
            mem_data[wr_ptr] <= push_data_c;
            mem_pe[wr_ptr]   <= push_pe_c;
            mem_fe[wr_ptr]   <= push_fe_c;
            mem_bi[wr_ptr]   <= push_bi_c;
        end
    end

    assign rx_data    = rx_empty ? 8'h00 : mem_data[rd_ptr];
    assign rx_pe      = !rx_empty && mem_pe[rd_ptr];
    assign rx_fe      = !rx_empty && mem_fe[rd_ptr];
    assign rx_bi      = !rx_empty && mem_bi[rd_ptr];
    assign fifo_error = |(valid & (mem_pe | mem_fe | mem_bi));

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: table vectors, randomized frames
// against a character-level model, and hand-written corner sequences.
module tb_uart_rx_engine;

    localparam int SP = 3;   // pclk cycles per sample_edge

    logic       pclk = 1'b0;
    logic       utrrst, sample_edge, uart_rxd, loop_txd, loop;
    logic [1:0] wls;
    logic       pen, eps, sp, rx_rd, ovr_clr;
    logic [7:0] rx_data;
    logic       rx_pe, rx_fe, rx_bi, rx_empty, rx_full;
    logic [2:0] rx_count;
    logic       overrun, fifo_error, rx_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int scnt     = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
    } entry_t;

    typedef struct {
        logic [1:0] wls;
        logic       pen, eps, sp;
        logic [7:0] data;
        logic       par, stop;
        logic [7:0] e_data;
        logic       e_pe, e_fe, e_bi;
    } vec_t;

    vec_t   vecs[12];
    entry_t mq[$];

    uart_rx_engine #(.OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
        .pclk(pclk), .utrrst(utrrst), .sample_edge(sample_edge),
        .uart_rxd(uart_rxd), .loop_txd(loop_txd), .loop(loop),
        .wls(wls), .pen(pen), .eps(eps), .sp(sp),
        .rx_rd(rx_rd), .ovr_clr(ovr_clr),
        .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
        .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count),
        .overrun(overrun), .fifo_error(fifo_error), .rx_busy(rx_busy)
    );

    always #5 pclk = ~pclk;

    // Baud tick: one pclk wide every SP cycles
    initial begin
        sample_edge = 1'b0;
        forever begin
            @(negedge pclk);
            sample_edge = (scnt == 0);
            scnt = (scnt + 1) % SP;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Returns at the negedge following the next sampled sample_edge
    task automatic tick_wait();
        do @(posedge pclk); while (!sample_edge);
        @(negedge pclk);
    endtask

    task automatic set_line(input logic via_loop, input logic v);
        if (via_loop) loop_txd = v;
        else          uart_rxd = v;
    endtask

    task automatic pop();
        @(negedge pclk); rx_rd = 1'b1;
        @(negedge pclk); rx_rd = 1'b0;
    endtask

    // Character-level reference: what one frame should leave in the FIFO
    function automatic entry_t model(input logic [7:0] d, input int n, input logic fpen,
                                     input logic feps, input logic fsp, input logic par,
                                     input logic stop);
        entry_t e;
        int     ones;
        logic   ep;
        e.data = d & 8'((1 << n) - 1);
        ones   = $countones(e.data);
        ep     = fsp ? !feps : (feps ? ones[0] : !ones[0]);
        e.bi   = (e.data == 8'h00) && (!fpen || !par) && !stop;
        e.fe   = !stop;
        e.pe   = e.bi ? 1'b0 : (fpen && (par != ep));
        return e;
    endfunction

    task automatic send_frame(input logic [7:0] d, input int n, input logic fpen,
                              input logic par, input logic stop, input int glitch_bit,
                              input logic pop_at_stop, input logic via_loop);
        logic [11:0] bits;
        int          nb;
        bits = '1;
        nb   = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < n; i++) begin bits[nb] = d[i]; nb++; end
        if (fpen) begin bits[nb] = par; nb++; end
        bits[nb] = stop; nb++;
        tick_wait();
        for (int j = 0; j < nb; j++) begin
            set_line(via_loop, bits[j]);
            if (j == glitch_bit) begin
                repeat (8) tick_wait();
                set_line(via_loop, ~bits[j]);
                tick_wait();
                set_line(via_loop, bits[j]);
                repeat (7) tick_wait();
            end else if (pop_at_stop && (j == nb - 1)) begin
                repeat (10) tick_wait();
                repeat (SP - 1) @(negedge pclk);
                rx_rd = 1'b1;
                @(negedge pclk);
                rx_rd = 1'b0;
                repeat (5) tick_wait();
            end else begin
                repeat (16) tick_wait();
            end
        end
        set_line(via_loop, 1'b1);
    endtask

    task automatic check_head(input string tag, input entry_t e);
        check({tag, "_data"}, 32'(rx_data), 32'(e.data));
        check({tag, "_pe"},   32'(rx_pe),   32'(e.pe));
        check({tag, "_fe"},   32'(rx_fe),   32'(e.fe));
        check({tag, "_bi"},   32'(rx_bi),   32'(e.bi));
    endtask

    initial begin
        entry_t e;
        int     nfr;
        logic   any_err;
        logic [7:0] d;
        logic   p;

        uart_rxd = 1'b1; loop_txd = 1'b1; loop = 1'b0;
        wls = 2'd3; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        rx_rd = 1'b0; ovr_clr = 1'b0; utrrst = 1'b1;
        repeat (4) @(negedge pclk);
        utrrst = 1'b0;
        @(negedge pclk);

        check("rst_empty",   32'(rx_empty),   32'd1);
        check("rst_full",    32'(rx_full),    32'd0);
        check("rst_count",   32'(rx_count),   32'd0);
        check("rst_overrun", 32'(overrun),    32'd0);
        check("rst_ferr",    32'(fifo_error), 32'd0);
        check("rst_busy",    32'(rx_busy),    32'd0);
        check("rst_data",    32'(rx_data),    32'd0);

        //            wls   pen   eps   sp    data   par   stop  e_data e_pe e_fe e_bi
        vecs[0]  = '{2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'd2, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b1, 8'h35, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{2'd2, 1'b1, 1'b1, 1'b0, 8'h35, 1'b0, 1'b1, 8'h35, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'd0, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'd3, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{2'd3, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2'd3, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{2'd2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{2'd0, 1'b0, 1'b0, 1'b0, 8'hE0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'd2, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0};

        for (int v = 0; v < 12; v++) begin
            wls = vecs[v].wls; pen = vecs[v].pen; eps = vecs[v].eps; sp = vecs[v].sp;
            send_frame(vecs[v].data, 5 + int'(vecs[v].wls), vecs[v].pen, vecs[v].par,
                       vecs[v].stop, -1, 1'b0, 1'b0);
            repeat (32) tick_wait();
            check($sformatf("vec%0d_count", v), 32'(rx_count), 32'd1);
            e = '{vecs[v].e_data, vecs[v].e_pe, vecs[v].e_fe, vecs[v].e_bi};
            check_head($sformatf("vec%0d", v), e);
            check($sformatf("vec%0d_ferr", v), 32'(fifo_error),
                  32'(vecs[v].e_pe | vecs[v].e_fe | vecs[v].e_bi));
            pop();
            check($sformatf("vec%0d_empty", v), 32'(rx_empty), 32'd1);
            check($sformatf("vec%0d_ferr_pop", v), 32'(fifo_error), 32'd0);
            check($sformatf("vec%0d_busy", v), 32'(rx_busy), 32'd0);
        end

        // Randomized bursts of back-to-back frames against the model
        for (int g = 0; g < 6; g++) begin
            wls = 2'($urandom_range(0, 3));
            pen = 1'($urandom_range(0, 1));
            eps = 1'($urandom_range(0, 1));
            sp  = 1'($urandom_range(0, 1));
            nfr = $urandom_range(1, 3);
            any_err = 1'b0;
            for (int f = 0; f < nfr; f++) begin
                d = 8'($urandom);
                p = 1'($urandom_range(0, 1));
                e = model(d, 5 + int'(wls), pen, eps, sp, p, 1'b1);
                any_err = any_err | e.pe | e.fe | e.bi;
                mq.push_back(e);
                send_frame(d, 5 + int'(wls), pen, p, 1'b1, -1, 1'b0, 1'b0);
            end
            repeat (16) tick_wait();
            check($sformatf("rnd%0d_count", g), 32'(rx_count), 32'(nfr));
            check($sformatf("rnd%0d_ferr", g), 32'(fifo_error), 32'(any_err));
            while (mq.size() > 0) begin
                e = mq.pop_front();
                check_head($sformatf("rnd%0d", g), e);
                pop();
            end
            check($sformatf("rnd%0d_empty", g), 32'(rx_empty), 32'd1);
        end

        wls = 2'd3; pen = 1'b0; eps = 1'b0; sp = 1'b0;

        // Break: line low for 30 bit times
        tick_wait();
        uart_rxd = 1'b0;
        repeat (20 * 16) tick_wait();
        check("brk_busy_low", 32'(rx_busy), 32'd1);
        check("brk_count_low", 32'(rx_count), 32'd1);
        repeat (10 * 16) tick_wait();
        uart_rxd = 1'b1;
        repeat (32) tick_wait();
        check("brk_busy_high", 32'(rx_busy), 32'd0);
        check("brk_count", 32'(rx_count), 32'd1);
        check_head("brk", '{8'h00, 1'b0, 1'b1, 1'b1});
        pop();
        check("brk_empty", 32'(rx_empty), 32'd1);

        // False start: 3 ticks low
        tick_wait();
        uart_rxd = 1'b0;
        repeat (3) tick_wait();
        uart_rxd = 1'b1;
        check("fs_busy", 32'(rx_busy), 32'd1);
        repeat (32) tick_wait();
        check("fs_busy_end", 32'(rx_busy), 32'd0);
        check("fs_count", 32'(rx_count), 32'd0);

        // One-tick spike on a mid-bit sample of data bit 2
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        repeat (16) tick_wait();
        check("spike_count", 32'(rx_count), 32'd1);
        check_head("spike", '{8'h5A, 1'b0, 1'b0, 1'b0});
        pop();

        // Overflow: five characters into four slots
        for (int k = 1; k <= 5; k++)
            send_frame(8'(k * 8'h11), 8, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        repeat (16) tick_wait();
        check("ovf_full", 32'(rx_full), 32'd1);
        check("ovf_count", 32'(rx_count), 32'd4);
        check("ovf_overrun", 32'(overrun), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf_pop%0d", k), 32'(rx_data), 32'(k * 8'h11));
            pop();
        end
        check("ovf_empty", 32'(rx_empty), 32'd1);
        check("ovf_sticky", 32'(overrun), 32'd1);
        @(negedge pclk); ovr_clr = 1'b1;
        @(negedge pclk); ovr_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        // Same again, popping in the cycle of the fifth push
        for (int k = 1; k <= 5; k++)
            send_frame(8'(k * 8'h11), 8, 1'b0, 1'b0, 1'b1, -1, (k == 5), 1'b0);
        repeat (16) tick_wait();
        check("pp_overrun", 32'(overrun), 32'd0);
        check("pp_count", 32'(rx_count), 32'd4);
        check("pp_full", 32'(rx_full), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("pp_pop%0d", k), 32'(rx_data), 32'(k * 8'h11));
            pop();
        end
        check("pp_empty", 32'(rx_empty), 32'd1);

        // Loopback 6O1 with the pin held low
        loop = 1'b1; uart_rxd = 1'b0; loop_txd = 1'b1;
        wls = 2'd1; pen = 1'b1; eps = 1'b0; sp = 1'b0;
        repeat (16) tick_wait();
        send_frame(8'h2A, 6, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1);
        repeat (16) tick_wait();
        check("lb_count", 32'(rx_count), 32'd1);
        check_head("lb", '{8'h2A, 1'b0, 1'b0, 1'b0});

        // Reset mid-frame, leaving the earlier entry unpopped
        tick_wait();
        loop_txd = 1'b0;
        repeat (40) tick_wait();
        check("mid_busy", 32'(rx_busy), 32'd1);
        utrrst = 1'b1; loop_txd = 1'b1;
        @(negedge pclk);
        utrrst = 1'b0;
        @(negedge pclk);
        check("mid_rst_busy",  32'(rx_busy),  32'd0);
        check("mid_rst_empty", 32'(rx_empty), 32'd1);
        check("mid_rst_count", 32'(rx_count), 32'd0);
        check("mid_rst_data",  32'(rx_data),  32'd0);
        repeat (32) tick_wait();
        check("mid_no_push", 32'(rx_count), 32'd0);
        send_frame(8'h15, 6, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1);
        repeat (16) tick_wait();
        check("lb2_count", 32'(rx_count), 32'd1);
        check_head("lb2", '{8'h15, 1'b0, 1'b0, 1'b0});
        pop();
        check("lb2_empty", 32'(rx_empty), 32'd1);

        loop = 1'b0; uart_rxd = 1'b1;
        repeat (8) @(negedge pclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
